// File: rtl/bitrev_spi_ctrl.sv
// SPI master plus 2-requester round-robin arbiter for the bit-reverse slave.
// One request byte -> one SS-framed exchange (8 TX + 8 RX SCK periods) -> one response.
module bitrev_spi_ctrl #(
  parameter int DIV_W     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [DIV_W-1:0] div,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [15:0]      req_data,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             sck,
  output logic             ss,
  output logic             mosi,
  input  logic             miso
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GUARD = 3'd1,
    TX    = 3'd2,
    RX    = 3'd3,
    HOLD  = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t           state, state_d;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] timer;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_sr;
  logic [7:0]       rx_sr;
  logic             gnt;
  logic             rr_ptr;
  logic             live;

  logic             gnt_d;
  logic [7:0]       req_byte;
  logic             grant_fire;
  logic             phase_end;
  logic             in_data;
  logic             rise;
  logic             fall;
  logic             last_bit;
  logic             load_rsp;
  logic             rsp_fire;

  // Handshakes: a transfer happens on the rising clock edge where valid and
  // ready are both high. req_ready is offered only in IDLE, for the granted
  // requester, so it is high for exactly one cycle per grant. rsp_valid is
  // held with stable rsp_data until the matching rsp_ready bit is seen.
  always_comb begin
    gnt_d      = rr_ptr ? (req_valid[1] ? 1'b1 : 1'b0)
                        : (req_valid[0] ? 1'b0 : 1'b1);
    req_byte   = gnt_d ? req_data[15:8] : req_data[7:0];
    phase_end  = (timer == '0);
    in_data    = (state == TX) || (state == RX);
    rise       = in_data && phase_end && !sck;
    fall       = in_data && phase_end && sck;
    last_bit   = (bit_cnt == 3'd7);
    grant_fire = (state == IDLE) && live && (req_valid != 2'b00);
    load_rsp   = (state == HOLD) && phase_end;
    rsp_fire   = (state == RESP) && rsp_ready[gnt];
    req_ready  = grant_fire ? (2'b01 << gnt_d) : 2'b00;

    state_d = state;
    case (state)
      IDLE:    if (grant_fire)       state_d = GUARD;
      GUARD:   if (phase_end)        state_d = TX;
      TX:      if (fall && last_bit) state_d = RX;
      RX:      if (fall && last_bit) state_d = HOLD;
      HOLD:    if (phase_end)        state_d = RESP;
      RESP:    if (rsp_fire)         state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      live      <= 1'b0;
      div_q     <= '0;
      timer     <= '0;
      bit_cnt   <= 3'd0;
      tx_sr     <= 8'h00;
      rx_sr     <= 8'h00;
      gnt       <= 1'b0;
      rr_ptr    <= 1'b0;
      ss        <= 1'b1;
      sck       <= 1'b0;
      mosi      <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_valid <= 2'b00;
    end else begin
      // Holds off the first grant until the cycle after reset release.
      live <= 1'b1;

      if (grant_fire) begin
        timer <= div;
      end else if (state == GUARD || in_data || state == HOLD) begin
        if (phase_end) timer <= div_q;
        else           timer <= timer - DIV_W'(1);
      end

      if (grant_fire) begin
        div_q   <= div;
        gnt     <= gnt_d;
        rr_ptr  <= ~gnt_d;
        tx_sr   <= req_byte;
        mosi    <= LSB_FIRST ? req_byte[0] : req_byte[7];
        ss      <= 1'b0;
        sck     <= 1'b0;
        bit_cnt <= 3'd0;
      end

      if (rise) begin
        sck <= 1'b1;
        if (state == RX) begin
          if (LSB_FIRST) rx_sr <= {miso, rx_sr[7:1]};
          else           rx_sr <= {rx_sr[6:0], miso};
        end
      end

      // The last TX bit stays on mosi through RX: the slave's first result
      // bit is derived from the live mosi level.
      if (fall) begin
        sck     <= 1'b0;
        bit_cnt <= bit_cnt + 3'd1;
        if (state == TX && !last_bit) begin
          if (LSB_FIRST) begin
            tx_sr <= {1'b0, tx_sr[7:1]};
            mosi  <= tx_sr[1];
          end else begin
            tx_sr <= {tx_sr[6:0], 1'b0};
            mosi  <= tx_sr[6];
          end
        end
      end

      if (load_rsp) begin
        ss        <= 1'b1;
        mosi      <= 1'b0;
        rsp_data  <= rx_sr;
        rsp_valid <= 2'b01 << gnt;
      end

      if (rsp_fire) rsp_valid <= 2'b00;
    end
  end

  a_req_ready_onehot0 : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(req_ready));
  a_rsp_valid_onehot0 : assert property (@(posedge clock) disable iff (!reset_n)
    $onehot0(rsp_valid));

endmodule

// File: tb/tb_bitrev_spi_ctrl.sv
// Directed bench for bitrev_spi_ctrl with a behavioural bit-reverse SPI slave.
module tb_bitrev_spi_ctrl;

  logic        clock;
  logic        reset_n;
  logic [7:0]  div;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_data;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_data;
  logic        sck;
  logic        ss;
  logic        mosi;
  logic        miso;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  bitrev_spi_ctrl #(.DIV_W(8), .LSB_FIRST(1'b1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .div       (div),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .sck       (sck),
    .ss        (ss),
    .mosi      (mosi),
    .miso      (miso)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Slave: captures 8 bits LSB first, returns them reversed LSB first.
  // Its first result bit is the live mosi level.
  logic [7:0] s_in;
  int         s_n;
  always @(posedge sck or posedge ss) begin
    if (ss) begin
      s_n <= 0;
    end else begin
      if (s_n < 8) s_in[s_n] <= mosi;
      s_n <= s_n + 1;
    end
  end

  always_comb begin
    miso = 1'b0;
    if (s_n == 8)                miso = mosi;
    else if (s_n > 8 && s_n < 16) miso = s_in[15 - s_n];
  end

  // ss high time between frames
  int   hi_run = 0;
  int   gap_bad = 0;
  logic ss_prev = 1'b1;
  bit   seen_frame = 1'b0;
  always @(negedge clock) begin
    hi_run <= ss ? hi_run + 1 : 0;
    if (!ss && ss_prev && seen_frame && hi_run < 2) gap_bad <= gap_bad + 1;
    if (!ss) seen_frame <= 1'b1;
    ss_prev <= ss;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_grant(input int id, output bit ok);
    logic [1:0] seen;
    seen = 2'b00;
    ok   = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clock);
      if (req_ready != 2'b00) begin
        seen = req_ready;
        ok   = 1'b1;
      end
    end
    check("grant", seen, 2'b01 << id);
  endtask

  // One full transaction: request, frame monitoring, response handshake.
  task automatic run_txn(input int id, input logic [7:0] data, input logic [7:0] exp,
                         input int dv, input int rsp_delay, input logic [1:0] drop_mask);
    bit   ok;
    bit   got_rsp;
    logic prev_sck;
    int   ss_low, rises, falls, run_len, tx_bad, hi_bad, lo_bad, hold_bad, stall_bad;
    logic [7:0] e;

    div = 8'(dv);
    req_data[8*id +: 8] = data;
    req_valid[id] = 1'b1;
    exp_q.push_back(exp);
    wait_grant(id, ok);
    @(posedge clock);
    #1 req_valid = req_valid & ~drop_mask;

    prev_sck = 1'b0;
    {ss_low, rises, falls, run_len, tx_bad, hi_bad, lo_bad, hold_bad} = '0;
    got_rsp = 1'b0;
    for (int c = 0; c < 5000 && !got_rsp; c++) begin
      @(negedge clock);
      if (rsp_valid != 2'b00) begin
        got_rsp = 1'b1;
      end else begin
        if (!ss) ss_low++;
        if (sck == prev_sck) begin
          run_len++;
        end else begin
          if (prev_sck && run_len != dv + 1) hi_bad++;
          if (!prev_sck && rises > 0 && run_len != dv + 1) lo_bad++;
          run_len = 1;
          if (sck) begin
            rises++;
            if (rises <= 8 && mosi !== data[rises-1]) tx_bad++;
          end else begin
            falls++;
          end
        end
        if (falls >= 8 && !ss && mosi !== data[7]) hold_bad++;
        prev_sck = sck;
      end
    end

    e = exp_q.pop_front();
    check("rsp_timeout", {31'd0, !got_rsp}, 32'd0);
    check("rsp_valid", rsp_valid, 2'b01 << id);
    check("rsp_data", rsp_data, e);
    check("ss_low_cycles", ss_low, 34 * (dv + 1));
    check("sck_rises", rises, 16);
    check("sck_falls", falls, 16);
    check("tx_bits", tx_bad, 0);
    check("sck_high_phase", hi_bad, 0);
    check("sck_low_phase", lo_bad, 0);
    check("mosi_hold_rx", hold_bad, 0);
    check("ss_after_frame", ss, 1);
    check("mosi_after_frame", mosi, 0);

    stall_bad = 0;
    if (rsp_delay > 0) rsp_ready[1-id] = 1'b1;
    for (int c = 0; c < rsp_delay; c++) begin
      @(negedge clock);
      if (rsp_data !== e || rsp_valid !== (2'b01 << id) || req_ready !== 2'b00 ||
          sck !== 1'b0 || ss !== 1'b1) stall_bad++;
    end
    check("resp_stall", stall_bad, 0);
    rsp_ready = 2'b00;
    rsp_ready[id] = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 2'b00;
    check("rsp_done", rsp_valid, 2'b00);
  endtask

  task automatic reset_abort();
    bit ok;
    int rises;
    logic prev_sck;
    div = 8'd1;
    req_data[7:0] = 8'hC4;
    req_valid[0] = 1'b1;
    wait_grant(0, ok);
    @(posedge clock);
    #1 req_valid[0] = 1'b0;
    rises = 0;
    prev_sck = 1'b0;
    for (int c = 0; c < 2000 && rises < 13; c++) begin
      @(negedge clock);
      if (sck && !prev_sck) rises++;
      prev_sck = sck;
    end
    check("abort_reached_rx5", rises, 13);
    #2 reset_n = 1'b0;
    #1;
    check("abort_ss", ss, 1);
    check("abort_sck", sck, 0);
    check("abort_mosi", mosi, 0);
    check("abort_rsp_valid", rsp_valid, 2'b00);
    check("abort_rsp_data", rsp_data, 8'h00);
    repeat (3) @(negedge clock);
    check("abort_req_ready", req_ready, 2'b00);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n   = 1'b1;
    div       = 8'd0;
    req_valid = 2'b11;
    req_data  = {8'h3C, 8'hA5};
    rsp_ready = 2'b00;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_ss", ss, 1);
    check("reset_sck", sck, 0);
    check("reset_mosi", mosi, 0);
    check("reset_req_ready", req_ready, 2'b00);
    check("reset_rsp_valid", rsp_valid, 2'b00);
    check("reset_rsp_data", rsp_data, 8'h00);
    reset_n = 1'b1;

    // both requesters held high from reset: grants alternate 0,1,0,1
    run_txn(0, 8'hA5, 8'hA5, 0, 0, 2'b00);
    run_txn(1, 8'h3C, 8'h3C, 0, 0, 2'b00);
    run_txn(0, 8'hA5, 8'hA5, 0, 0, 2'b00);
    run_txn(1, 8'h3C, 8'h3C, 0, 0, 2'b11);

    run_txn(0, 8'h01, 8'h80, 0, 0, 2'b01);
    run_txn(1, 8'h12, 8'h48, 3, 0, 2'b10);
    run_txn(1, 8'h0F, 8'hF0, 3, 1, 2'b10);
    run_txn(0, 8'hC4, 8'h23, 1, 20, 2'b01);

    reset_abort();
    run_txn(0, 8'h01, 8'h80, 0, 0, 2'b01);
    run_txn(1, 8'h80, 8'h01, 2, 0, 2'b10);

    repeat (2) @(negedge clock);
    check("ss_min_gap", gap_bad, 0);
    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
